// File: rtl/int_div.sv
// 32-bit restoring integer divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional INT_DIV_FAST_PATH_EN: zero dividend/divisor requests bypass the iteration loop.
//
// state  | meaning
// IDLE   | waiting for a request
// CALC   | 32 shift-subtract iterations, then one sign-fix cycle
// DONE   | o_result valid for one cycle; may accept the next request
module int_div (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        op_rem_q;
  logic        div_zero_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [5:0]  count_q;

  logic        accept;
  logic        signed_op;
  logic        fast;
  logic        last;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        no_borrow;
  logic [31:0] rem_it;
  logic [31:0] quo_it;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result_nxt;

  assign accept    = i_valid && ((state == S_IDLE) || (state == S_DONE));
  assign signed_op = ~i_op[0];
  assign a_mag     = (signed_op && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign b_mag     = (signed_op && i_b[31]) ? (~i_b + 32'd1) : i_b;
  assign last      = (count_q == 6'd32);

`ifdef INT_DIV_FAST_PATH_EN
  assign fast = (i_b == 32'd0) || (i_a == 32'd0);
`else
  assign fast = 1'b0;
`endif

  // Dividend bits shift out of quo_q's MSB as quotient bits shift into its LSB.
  assign rem_sh    = {rem_q, quo_q[31]};
  assign diff      = rem_sh - {1'b0, dvs_q};
  assign no_borrow = ~diff[32];
  assign rem_it    = no_borrow ? diff[31:0] : rem_sh[31:0];
  assign quo_it    = {quo_q[30:0], no_borrow};

  // A zero divisor yields all-ones quotient; the remainder already equals |a|.
  assign quo_fix    = div_zero_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
  assign rem_fix    = r_neg_q ? (~rem_q + 32'd1) : rem_q;
  assign result_nxt = op_rem_q ? rem_fix : quo_fix;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CALC;
      S_CALC:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_rem_q   <= 1'b0;
      div_zero_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      o_result   <= '0;
    end else if (accept) begin
      op_rem_q   <= i_op[1];
      div_zero_q <= (i_b == 32'd0);
      q_neg_q    <= signed_op & (i_a[31] ^ i_b[31]);
      r_neg_q    <= signed_op & i_a[31];
      quo_q      <= a_mag;
      dvs_q      <= b_mag;
      // Fast requests preload the final remainder and jump to the sign-fix cycle.
      rem_q      <= fast ? a_mag : 32'd0;
      count_q    <= fast ? 6'd32 : 6'd0;
    end else if (state == S_CALC) begin
      if (!last) begin
        rem_q   <= rem_it;
        quo_q   <= quo_it;
        count_q <= count_q + 6'd1;
      end else begin
        o_result <= result_nxt;
      end
    end
  end

  assign o_busy  = (state == S_CALC);
  assign o_valid = (state == S_DONE);

endmodule

// File: tb/tb_int_div.sv
// Self-checking bench for int_div: directed vector table plus back-to-back and reset sequences.
// Latency expectations follow INT_DIV_FAST_PATH_EN when defined.
module tb_int_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  int n_cmp = 0;
  int n_bad = 0;

  int_div dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef INT_DIV_FAST_PATH_EN
    return ((a == 32'd0) || (b == 32'd0)) ? 1 : 33;
`else
    return (a == b && a == 32'hDEAD_BEEF) ? 0 : 33;
`endif
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
  endtask

  // Waits for accept edge E0, scrambles operands, then measures edges until o_valid.
  task automatic collect(input string name, input logic [31:0] exp_res, input int lat);
    int  n;
    bit  got;
    bit  busy_ok;
    n = 0; got = 1'b0; busy_ok = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
    i_op    = 2'($urandom_range(0, 3));
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (o_valid) got = 1'b1;
      else if (!o_busy) busy_ok = 1'b0;
    end
    chk($sformatf("%s latency", name), 32'(n), 32'(lat));
    chk($sformatf("%s result", name), o_result, exp_res);
    chk($sformatf("%s busy", name), {31'd0, busy_ok}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s valid_pulse", name), {31'd0, o_valid}, 32'd0);
    chk($sformatf("%s hold", name), o_result, exp_res);
  endtask

  initial begin
    int  m;
    bit  got;
    bit  stray;

    vecs[0]  = '{OP_DIV,  32'd7,         32'd2,         32'h0000_0003};
    vecs[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[2]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF};
    vecs[3]  = '{OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F};
    vecs[4]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
    vecs[5]  = '{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    vecs[6]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[7]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{OP_DIV,  32'd100,       32'd3,         32'h0000_0021};
    vecs[9]  = '{OP_DIV,  32'hFFFF_FF9C, 32'd3,         32'hFFFF_FFDF};
    vecs[10] = '{OP_REM,  32'hFFFF_FF9C, 32'd3,         32'hFFFF_FFFF};
    vecs[11] = '{OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2};
    vecs[12] = '{OP_REM,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002};
    vecs[13] = '{OP_DIVU, 32'd0,         32'd5,         32'h0000_0000};
    vecs[14] = '{OP_REM,  32'd0,         32'd5,         32'h0000_0000};
    vecs[15] = '{OP_DIVU, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF};
    vecs[16] = '{OP_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678};
    vecs[17] = '{OP_DIVU, 32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA};

    // Reset state, with a request already pending for the first post-reset edge.
    i_valid = 1'b1; i_op = OP_DIV; i_a = 32'd7; i_b = 32'd2;
    #12;
    chk("rst busy",   {31'd0, o_busy},  32'd0);
    chk("rst valid",  {31'd0, o_valid}, 32'd0);
    chk("rst result", o_result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    collect("first_after_rst", 32'h0000_0003, 33);

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      collect($sformatf("vec%0d", i), vecs[i].res, exp_lat(vecs[i].a, vecs[i].b));
    end

    // Held i_valid with changed operands during CALC, then back-to-back accept in DONE.
    issue(OP_DIV, 32'd100, 32'd3);
    @(posedge clk);
    #1;
    i_op = OP_DIVU; i_a = 32'd50; i_b = 32'd7;
    m = 0; got = 1'b0;
    while (!got && m < 40) begin
      @(posedge clk); m++; @(negedge clk);
      if (o_valid) got = 1'b1;
    end
    chk("b2b first latency", 32'(m), 32'd33);
    chk("b2b first result",  o_result, 32'h0000_0021);
    m = 0; got = 1'b0;
    while (!got && m < 40) begin
      @(posedge clk); m++; @(negedge clk);
      if (o_valid) got = 1'b1;
    end
    i_valid = 1'b0;
    chk("b2b gap",           32'(m), 32'd34);
    chk("b2b second result", o_result, 32'h0000_0007);
    repeat (2) @(posedge clk);

    // Reset at iteration 10 of DIV 100/3.
    issue(OP_DIV, 32'd100, 32'd3);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy",   {31'd0, o_busy},  32'd0);
    chk("midrst valid",  {31'd0, o_valid}, 32'd0);
    chk("midrst result", o_result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid || o_busy) stray = 1'b1;
    end
    chk("midrst no_valid", {31'd0, stray}, 32'd0);
    issue(OP_DIV, 32'd100, 32'd3);
    collect("after_midrst", 32'h0000_0021, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
